// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer/response constants and default-slave state encodings
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // Only NONSEQ/SEQ carry data; IDLE/BUSY always complete OKAY with no wait.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - default slave FSM producing the two-cycle ERROR response
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hreset,
    input  logic capture,
    input  logic err_req,
    output logic ds_hready,
    output logic ds_hresp
);

    ds_state_t state, state_nxt;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ds_hready = 1'b1;
        ds_hresp  = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (capture && err_req) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = HRESP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                ds_hresp  = HRESP_ERROR;
                // hready is high here, so a new address phase may be captured back-to-back
                state_nxt = (capture && err_req) ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// rtl/ahb_resp_mux_n.sv - AHB-Lite slave response mux with default slave; AHB_MUX_TIMEOUT_EN adds a stall watchdog
module ahb_resp_mux_n
    import ahb_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32,
    parameter int TO_CYC  = 16
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic [NUM_SLV-1:0]        hsel_vec,
    input  logic [1:0]                htrans,
    input  logic [NUM_SLV*DATA_W-1:0] hrdata_vec,
    input  logic [NUM_SLV-1:0]        hreadyout_vec,
    input  logic [NUM_SLV-1:0]        hresp_vec,
    output logic [DATA_W-1:0]         hrdata,
    output logic                      hready,
    output logic                      hresp,
    output logic                      sel_err,
    output logic                      to_irq
);

    localparam logic [NUM_SLV:0] SEL_DEF = {1'b1, {NUM_SLV{1'b0}}};

    logic [NUM_SLV:0] dp_sel;
    logic [NUM_SLV:0] cap_sel;
    logic             capture;
    logic             unmapped;
    logic             multi_hot;
    logic             err_req;
    logic             ds_capture;
    logic             ds_hready;
    logic             ds_hresp;
    logic             timeout_hit;

    assign capture   = hready;
    assign unmapped  = (hsel_vec == '0);
    assign multi_hot = ($countones(hsel_vec) > 1);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        cap_sel          = '0;
        cap_sel[NUM_SLV] = unmapped;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (hsel_vec[i]) begin
                cap_sel    = '0;
                cap_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dp_sel  <= SEL_DEF;
            sel_err <= 1'b0;
        end else begin
            sel_err <= capture && multi_hot;
            if (timeout_hit) begin
                dp_sel <= SEL_DEF;
            end else if (capture) begin
                dp_sel <= cap_sel;
            end
        end
    end

    always_comb begin
        hrdata = '0;
        hready = ds_hready;
        hresp  = ds_hresp;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dp_sel[i]) begin
                hrdata = hrdata_vec[i*DATA_W +: DATA_W];
                hready = hreadyout_vec[i];
                hresp  = hresp_vec[i];
            end
        end
    end

    // A watchdog expiry looks to the default slave like a captured unmapped access.
    assign ds_capture = capture || timeout_hit;
    assign err_req    = timeout_hit || (capture && unmapped && is_active(htrans));

    ahb_default_slave u_default_slave (
        .hclk      (hclk),
        .hreset    (hreset),
        .capture   (ds_capture),
        .err_req   (err_req),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp)
    );

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             stall;
    logic             to_irq_q;

    // Capture needs hready high, so any change of dp_sel also drops stall and clears the count.
    assign stall       = !dp_sel[NUM_SLV] && !hready;
    assign timeout_hit = stall && (to_cnt == TO_LAST);
    assign to_irq      = to_irq_q;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            to_cnt   <= '0;
            to_irq_q <= 1'b0;
        end else begin
            to_irq_q <= timeout_hit;
            if (stall && !timeout_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end
`else
    logic unused_to_cyc;

    assign unused_to_cyc = (TO_CYC > 1);
    assign timeout_hit   = 1'b0;
    assign to_irq        = 1'b0;
`endif

endmodule
